// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-execute bundle: decoded fields flow in on id_*, the registered
// execute view flows out on ex_*.
//
// Handshake: valid-only pipeline. id_valid qualifies the id_* fields on the
// edge that captures them. ex_valid qualifies ex_* for the whole cycle. There
// is no ready signal: back-pressure comes from the stall/flush controls on
// the stage itself.
interface id_ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [6:0]            id_opcode;
  logic [2:0]            id_func3;
  logic [6:0]            id_func7;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_alu_src;

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [6:0]            ex_opcode;
  logic [2:0]            ex_func3;
  logic [6:0]            ex_func7;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic [XLEN-1:0]       ex_op1;
  logic [XLEN-1:0]       ex_op2;
  logic [XLEN-1:0]       ex_store_data;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_opcode,
           id_func3, id_func7, id_rd, id_reg_write, id_alu_src,
    input  ex_valid, ex_pc, ex_opcode, ex_func3, ex_func7, ex_rd,
           ex_reg_write, ex_op1, ex_op2, ex_store_data
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_opcode,
           id_func3, id_func7, id_rd, id_reg_write, id_alu_src,
    output ex_valid, ex_pc, ex_opcode, ex_func3, ex_func7, ex_rd,
           ex_reg_write, ex_op1, ex_op2, ex_store_data
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and execute operand select.
// Update priority on each edge: flush, then stall, then normal load.
module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_ex_operand_stage_if.slave bus,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [1:0]           forward_a,
  input  logic [1:0]           forward_b,
  input  logic [XLEN-1:0]      mem_fwd_data,
  input  logic [XLEN-1:0]      wb_fwd_data
);
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic                  valid_q,     valid_d;
  logic [XLEN-1:0]       pc_q,        pc_d;
  logic [XLEN-1:0]       rs1_q,       rs1_d;
  logic [XLEN-1:0]       rs2_q,       rs2_d;
  logic [XLEN-1:0]       imm_q,       imm_d;
  logic [6:0]            opcode_q,    opcode_d;
  logic [2:0]            func3_q,     func3_d;
  logic [6:0]            func7_q,     func7_d;
  logic [REG_ADDR_W-1:0] rd_q,        rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  alu_src_q,   alu_src_d;

  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;
  logic [XLEN-1:0] op1;

  // Code 11 is reserved and falls through to the stored register value.
  always_comb begin
    fa = rs1_q;
    case (forward_a)
      2'b01:   fa = mem_fwd_data;
      2'b10:   fa = wb_fwd_data;
      default: fa = rs1_q;
    endcase
    fb = rs2_q;
    case (forward_b)
      2'b01:   fb = mem_fwd_data;
      2'b10:   fb = wb_fwd_data;
      default: fb = rs2_q;
    endcase
  end

  always_comb begin
    op1 = fa;
    case (opcode_q)
      OP_AUIPC, OP_JAL: op1 = pc_q;
      OP_LUI:           op1 = '0;
      default:          op1 = fa;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    opcode_d    = opcode_q;
    func3_d     = func3_q;
    func7_d     = func7_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    alu_src_d   = alu_src_q;
    if (flush) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      imm_d       = '0;
      opcode_d    = '0;
      func3_d     = '0;
      func7_d     = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      alu_src_d   = 1'b0;
    end else if (stall) begin
      // Latch the forwarded operands so they survive the producer retiring
      // while this instruction is held; fa/fb equal the stored value otherwise.
      rs1_d = fa;
      rs2_d = fb;
    end else begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      rs1_d       = bus.id_rs1_data;
      rs2_d       = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      opcode_d    = bus.id_opcode;
      func3_d     = bus.id_func3;
      func7_d     = bus.id_func7;
      rd_d        = bus.id_rd;
      reg_write_d = bus.id_reg_write & bus.id_valid;
      alu_src_d   = bus.id_alu_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      opcode_q    <= '0;
      func3_q     <= '0;
      func7_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      opcode_q    <= opcode_d;
      func3_q     <= func3_d;
      func7_q     <= func7_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      alu_src_q   <= alu_src_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_opcode     = opcode_q;
  assign bus.ex_func3      = func3_q;
  assign bus.ex_func7      = func7_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_op1        = op1;
  assign bus.ex_op2        = alu_src_q ? imm_q : fb;
  assign bus.ex_store_data = fb;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic,
// checked against an instruction-slot reference model through a queue.
module tb_id_ex_operand_stage;
  localparam int W = 152;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_fwd_data;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .stall        (stall),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_data  (wb_fwd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        rw, alu_src;
  } slot_t;

  slot_t m;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    m = '{valid: 1'b0, pc: 32'h0, rs1: 32'h0, rs2: 32'h0, imm: 32'h0,
          opcode: 7'h0, func7: 7'h0, func3: 3'h0, rd: 5'h0, rw: 1'b0, alu_src: 1'b0};
  endtask

  function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] base);
    if (sel == 2'd1) return mem_fwd_data;
    if (sel == 2'd2) return wb_fwd_data;
    return base;
  endfunction

  task automatic model_clock();
    if (flush) begin
      model_reset();
    end else if (stall) begin
      m.rs1 = pick(forward_a, m.rs1);
      m.rs2 = pick(forward_b, m.rs2);
    end else begin
      m.valid   = bus.id_valid;
      m.pc      = bus.id_pc;
      m.rs1     = bus.id_rs1_data;
      m.rs2     = bus.id_rs2_data;
      m.imm     = bus.id_imm;
      m.opcode  = bus.id_opcode;
      m.func3   = bus.id_func3;
      m.func7   = bus.id_func7;
      m.rd      = bus.id_rd;
      m.rw      = bus.id_reg_write && bus.id_valid;
      m.alu_src = bus.id_alu_src;
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [31:0] fa, fb, op1, op2;
    fa = pick(forward_a, m.rs1);
    fb = pick(forward_b, m.rs2);
    if (m.opcode == 7'b0010111 || m.opcode == 7'b1101111) op1 = m.pc;
    else if (m.opcode == 7'b0110111)                      op1 = 32'h0;
    else                                                  op1 = fa;
    op2 = m.alu_src ? m.imm : fb;
    return {m.valid, m.pc, m.opcode, m.func3, m.func7, m.rd, m.rw, op1, op2, fb};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {bus.ex_valid, bus.ex_pc, bus.ex_opcode, bus.ex_func3, bus.ex_func7,
            bus.ex_rd, bus.ex_reg_write, bus.ex_op1, bus.ex_op2, bus.ex_store_data};
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    check(name, {120'h0, act}, {120'h0, exp});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(logic v, logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                        logic [31:0] imm, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                        logic [4:0] rd, logic rw, logic asrc);
    bus.id_valid = v;    bus.id_pc = pc;        bus.id_rs1_data = rs1;
    bus.id_rs2_data = rs2; bus.id_imm = imm;    bus.id_opcode = op;
    bus.id_func3 = f3;   bus.id_func7 = f7;     bus.id_rd = rd;
    bus.id_reg_write = rw; bus.id_alu_src = asrc;
  endtask

  task automatic set_ctl(logic st, logic fl, logic [1:0] fwa, logic [1:0] fwb,
                         logic [31:0] mem, logic [31:0] wb);
    stall = st; flush = fl; forward_a = fwa; forward_b = fwb;
    mem_fwd_data = mem; wb_fwd_data = wb;
  endtask

  // One clock edge: model follows the DUT, expected response is queued.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) check("scoreboard", dut_vec(), exp_q.pop_front());
  end

  // ---------------- stimulus ----------------
  logic [6:0] ops [8];
  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0010111; ops[3] = 7'b0110111;
    ops[4] = 7'b1101111; ops[5] = 7'b0100011; ops[6] = 7'b0000011; ops[7] = 7'b1100011;

    rst_n = 1'b0;
    model_reset();
    set_id(1'b0, 0, 0, 0, 0, 7'h0, 3'h0, 7'h0, 5'h0, 1'b0, 1'b0);
    set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    #1;
    check("reset_state", dut_vec(), {W{1'b0}});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal SLTI
    set_id(1'b1, 32'h40, 32'hFFFF_FFFE, 32'h9, 32'h0000_0003, 7'b0010011, 3'b010, 7'h0, 5'd3, 1'b1, 1'b1);
    step();
    check32("slti_op1", bus.ex_op1, 32'hFFFF_FFFE);
    check32("slti_op2", bus.ex_op2, 32'h0000_0003);
    check32("slti_valid", {31'h0, bus.ex_valid}, 32'h1);

    // Forwarding on a held register value (no clock edge in between)
    set_id(1'b1, 32'h44, 32'h5, 32'h6, 32'h0, 7'b0110011, 3'b010, 7'h0, 5'd4, 1'b1, 1'b0);
    step();
    set_ctl(1'b0, 1'b0, 2'd1, 2'd0, 32'h10, 32'h0);
    #1 check32("fwd_mem", bus.ex_op1, 32'h10);
    set_ctl(1'b0, 1'b0, 2'd2, 2'd0, 32'h10, 32'h20);
    #1 check32("fwd_wb", bus.ex_op1, 32'h20);
    set_ctl(1'b0, 1'b0, 2'd3, 2'd0, 32'h10, 32'h20);
    #1 check32("fwd_reserved", bus.ex_op1, 32'h5);
    @(negedge clk);

    // Stall with forwarded-value refresh
    set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    set_id(1'b1, 32'h48, 32'h1, 32'h33, 32'h8, 7'b0100011, 3'b010, 7'h0, 5'd0, 1'b0, 1'b1);
    step();
    set_id(1'b1, 32'h4C, 32'hAA, 32'hBB, 32'hCC, 7'b0110011, 3'b000, 7'h20, 5'd9, 1'b1, 1'b0);
    set_ctl(1'b1, 1'b0, 2'd0, 2'd2, 32'h0, 32'h77);
    step();
    check32("stall_sd1", bus.ex_store_data, 32'h77);
    set_ctl(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    check32("stall_sd2", bus.ex_store_data, 32'h77);
    check32("stall_opcode", {25'h0, bus.ex_opcode}, {25'h0, 7'b0100011});
    check32("stall_pc", bus.ex_pc, 32'h48);

    // Flush beats stall
    set_ctl(1'b1, 1'b1, 2'd0, 2'd0, 32'h0, 32'h0);
    set_id(1'b1, 32'h50, 32'h3, 32'h4, 32'h0, 7'b0110011, 3'b010, 7'h0, 5'd7, 1'b1, 1'b0);
    step();
    check32("flush_ctl", {bus.ex_valid, bus.ex_reg_write, bus.ex_opcode, bus.ex_rd},
            32'h0);

    // AUIPC / LUI operand 1 selection
    set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
    set_id(1'b1, 32'h100, 32'h55, 32'h66, 32'h0000_1000, 7'b0010111, 3'b000, 7'h0, 5'd1, 1'b1, 1'b1);
    step();
    check32("auipc_op1", bus.ex_op1, 32'h100);
    check32("auipc_op2", bus.ex_op2, 32'h0000_1000);
    set_id(1'b1, 32'h104, 32'h55, 32'h66, 32'hABCD_E000, 7'b0110111, 3'b000, 7'h0, 5'd2, 1'b1, 1'b1);
    step();
    check32("lui_op1", bus.ex_op1, 32'h0);
    check32("lui_op2", bus.ex_op2, 32'hABCD_E000);

    // Asynchronous reset in mid-cycle
    set_id(1'b1, 32'h108, 32'h1234, 32'h1, 32'h0, 7'b0110011, 3'b010, 7'h0, 5'd5, 1'b1, 1'b0);
    step();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check32("async_rst_ctl", {24'h0, bus.ex_valid, bus.ex_opcode}, 32'h0);
    check32("async_rst_op1", bus.ex_op1, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    set_id(1'b0, 32'h10C, 32'h7, 32'h8, 32'h9, 7'b0110011, 3'b000, 7'h0, 5'd6, 1'b1, 1'b0);
    step();
    check32("post_rst_no_valid", {30'h0, bus.ex_valid, bus.ex_reg_write}, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom,
             ops[$urandom_range(0, 7)], 3'($urandom), 7'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom));
      set_ctl(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
              2'($urandom), 2'($urandom), $urandom, $urandom);
      step();
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
